// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encoding,
// port count and the access-size codes carried through to the RAM.
package ram_arb_pkg;

    localparam int NUM_PORTS = 2;

    // Access-size codes; the arbiter forwards them without interpretation.
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way winner select. With fixed set, port 0 wins any tie; otherwise
// the pointer names the preferred port on a tie, and a lone requester
// always wins. The output is only meaningful when at least one req is set.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 ptr,
    input  logic                 fixed,
    output logic                 winner
);

    // Pick the winning port index from the request pair.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves winner
        // unassigned, which would otherwise infer a latch.
        winner = 1'b0;
        if (fixed) begin
            winner = ~req[0];
        end else if (req == 2'b11) begin
            winner = ptr;
        end else begin
            winner = req[1];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-cycle-read RAM. Each access runs
// IDLE -> ISSUE -> RESP -> IDLE: grant pulses in ISSUE, the RAM returns
// data during RESP, and the completion pulse appears in the following cycle.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_,
    // port 0: CPU data
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [1:0]        size0,
    input  logic              se0,
    input  logic [31:0]       wdata0,
    output logic              gnt0,
    output logic              ack0,
    output logic [31:0]       rdata0,
    // port 1: debug / loader
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [1:0]        size1,
    input  logic              se1,
    input  logic [31:0]       wdata1,
    output logic              gnt1,
    output logic              ack1,
    output logic [31:0]       rdata1,
    // RAM side
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [1:0]        ram_size,
    output logic              ram_se,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_t state;
    logic   ptr;        // preferred port on a tie (round-robin only)
    logic   cur_port;   // port owning the access in flight
    logic   cur_we;     // access in flight is a write
    logic   pick;

    rr_pick2 u_pick (
        .req    ({req1, req0}),
        .ptr    (ptr),
        .fixed  (FIXED_PRIO),
        .winner (pick)
    );

    // Arbitration FSM; every output is a register so the RAM and both
    // requesters see glitch-free strobes. Reset aborts any access at once.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            cur_port  <= 1'b0;
            cur_we    <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_size  <= 2'd0;
            ram_se    <= 1'b0;
            ram_wdata <= 32'd0;
            rdata0    <= 32'd0;
            rdata1    <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register sees the pre-edge values of the others.
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        cur_port  <= pick;
                        cur_we    <= pick ? we1 : we0;
                        ram_we    <= pick ? we1 : we0;
                        ram_addr  <= pick ? addr1 : addr0;
                        ram_size  <= pick ? size1 : size0;
                        ram_se    <= pick ? se1 : se0;
                        ram_wdata <= pick ? wdata1 : wdata0;
                        gnt0      <= ~pick;
                        gnt1      <= pick;
                        if (!FIXED_PRIO) begin
                            ptr <= ~pick;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= RESP;
                end
                RESP: begin
                    if (!cur_we) begin
                        if (cur_port) begin
                            rdata1 <= ram_rdata;
                        end else begin
                            rdata0 <= ram_rdata;
                        end
                    end
                    ack0  <= ~cur_port;
                    ack1  <= cur_port;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one round-robin and one fixed-priority
// instance share the same request stimulus, each with its own RAM model.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic        clk;
    logic        rst_;
    logic        req0, we0, se0, req1, we1, se1;
    logic [7:0]  addr0, addr1;
    logic [1:0]  size0, size1;
    logic [31:0] wdata0, wdata1;

    logic        rr_gnt0, rr_gnt1, rr_ack0, rr_ack1, rr_ram_we, rr_ram_se;
    logic [31:0] rr_rdata0, rr_rdata1, rr_ram_wdata, rr_ram_rdata;
    logic [7:0]  rr_ram_addr;
    logic [1:0]  rr_ram_size;

    logic        fx_gnt0, fx_gnt1, fx_ack0, fx_ack1, fx_ram_we, fx_ram_se;
    logic [31:0] fx_rdata0, fx_rdata1, fx_ram_wdata, fx_ram_rdata;
    logic [7:0]  fx_ram_addr;
    logic [1:0]  fx_ram_size;

    logic [31:0] mem_rr [256];
    logic [31:0] mem_fx [256];

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.ADDR_W(8), .FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst_(rst_),
        .req0(req0), .we0(we0), .addr0(addr0), .size0(size0), .se0(se0), .wdata0(wdata0),
        .gnt0(rr_gnt0), .ack0(rr_ack0), .rdata0(rr_rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .size1(size1), .se1(se1), .wdata1(wdata1),
        .gnt1(rr_gnt1), .ack1(rr_ack1), .rdata1(rr_rdata1),
        .ram_addr(rr_ram_addr), .ram_we(rr_ram_we), .ram_size(rr_ram_size),
        .ram_se(rr_ram_se), .ram_wdata(rr_ram_wdata), .ram_rdata(rr_ram_rdata)
    );

    ram_arbiter #(.ADDR_W(8), .FIXED_PRIO(1'b1)) dut_fx (
        .clk(clk), .rst_(rst_),
        .req0(req0), .we0(we0), .addr0(addr0), .size0(size0), .se0(se0), .wdata0(wdata0),
        .gnt0(fx_gnt0), .ack0(fx_ack0), .rdata0(fx_rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .size1(size1), .se1(se1), .wdata1(wdata1),
        .gnt1(fx_gnt1), .ack1(fx_ack1), .rdata1(fx_rdata1),
        .ram_addr(fx_ram_addr), .ram_we(fx_ram_we), .ram_size(fx_ram_size),
        .ram_se(fx_ram_se), .ram_wdata(fx_ram_wdata), .ram_rdata(fx_ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM models: registered read, preloaded while reset is held.
    always @(posedge clk) begin
        if (!rst_) begin
            mem_rr[8'h10] <= 32'hDEADBEEF;
            mem_rr[8'h20] <= 32'h0;
            mem_rr[8'h30] <= 32'hA5A50030;
            mem_rr[8'h31] <= 32'h5A5A0031;
        end else if (rr_ram_we) begin
            mem_rr[rr_ram_addr] <= rr_ram_wdata;
        end
        rr_ram_rdata <= mem_rr[rr_ram_addr];
    end

    always @(posedge clk) begin
        if (!rst_) begin
            mem_fx[8'h10] <= 32'hDEADBEEF;
            mem_fx[8'h20] <= 32'h0;
            mem_fx[8'h30] <= 32'hA5A50030;
            mem_fx[8'h31] <= 32'h5A5A0031;
        end else if (fx_ram_we) begin
            mem_fx[fx_ram_addr] <= fx_ram_wdata;
        end
        fx_ram_rdata <= mem_fx[fx_ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected per-cycle strobes for the contention run, bit k = cycle E+k.
    localparam logic [15:0] RR_G0 = 16'h0082, RR_G1 = 16'h2410;
    localparam logic [15:0] RR_A0 = 16'h0208, RR_A1 = 16'h9040;
    localparam logic [15:0] FX_G0 = 16'h0492, FX_G1 = 16'h2000;
    localparam logic [15:0] FX_A0 = 16'h1248, FX_A1 = 16'h8000;

    initial begin
        rst_ = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; size0 = SIZE_WORD; se0 = 0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; size1 = SIZE_WORD; se1 = 0; wdata1 = '0;

        // Reset takes effect with no clock edge.
        #1 rst_ = 1'b0;
        #1;
        check("rst_outs", {28'd0, rr_gnt0, rr_gnt1, rr_ack0, rr_ack1}, 32'd0);
        check("rst_ram_we", {31'd0, rr_ram_we}, 32'd0);
        check("rst_ram_addr", {24'd0, rr_ram_addr}, 32'd0);
        check("rst_rdata0", rr_rdata0, 32'd0);
        check("rst_state", {30'd0, dut_rr.state}, {30'd0, IDLE});
        repeat (2) @(negedge clk);
        rst_ = 1'b1;

        // Read on port 0.
        req0 = 1; we0 = 0; addr0 = 8'h10; size0 = SIZE_HALF; se0 = 1;
        @(negedge clk);
        check("rd_gnt0", {31'd0, rr_gnt0}, 32'd1);
        check("rd_gnt1", {31'd0, rr_gnt1}, 32'd0);
        check("rd_we", {31'd0, rr_ram_we}, 32'd0);
        check("rd_addr", {24'd0, rr_ram_addr}, 32'h10);
        check("rd_size", {30'd0, rr_ram_size}, {30'd0, SIZE_HALF});
        check("rd_se", {31'd0, rr_ram_se}, 32'd1);
        check("rd_fx_gnt0", {31'd0, fx_gnt0}, 32'd1);
        req0 = 0;
        @(negedge clk);
        check("rd_gnt_drop", {30'd0, rr_gnt0, rr_ack0}, 32'd0);
        check("rd_addr_hold", {24'd0, rr_ram_addr}, 32'h10);
        @(negedge clk);
        check("rd_ack0", {31'd0, rr_ack0}, 32'd1);
        check("rd_rdata0", rr_rdata0, 32'hDEADBEEF);
        check("rd_fx_rdata0", fx_rdata0, 32'hDEADBEEF);
        @(negedge clk);
        check("rd_ack_pulse", {31'd0, rr_ack0}, 32'd0);

        // Write on port 1.
        req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 32'h12345678; size1 = SIZE_WORD; se1 = 0;
        @(negedge clk);
        check("wr_gnt1", {31'd0, rr_gnt1}, 32'd1);
        check("wr_we", {31'd0, rr_ram_we}, 32'd1);
        check("wr_wdata", rr_ram_wdata, 32'h12345678);
        check("wr_addr", {24'd0, rr_ram_addr}, 32'h20);
        req1 = 0;
        @(negedge clk);
        check("wr_we_drop", {31'd0, rr_ram_we}, 32'd0);
        check("wr_wdata_hold", rr_ram_wdata, 32'h12345678);
        @(negedge clk);
        check("wr_ack1", {31'd0, rr_ack1}, 32'd1);
        check("wr_rdata1", rr_rdata1, 32'd0);
        check("wr_rdata0", rr_rdata0, 32'hDEADBEEF);
        check("wr_mem", mem_rr[8'h20], 32'h12345678);
        @(negedge clk);

        // Both ports request reads; port 0 drops after 4 accesses, port 1 after its next grant.
        req0 = 1; we0 = 0; addr0 = 8'h30;
        req1 = 1; we1 = 0; addr1 = 8'h31;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check($sformatf("rr_c%0d", k), {28'd0, rr_gnt0, rr_gnt1, rr_ack0, rr_ack1},
                  {28'd0, RR_G0[k], RR_G1[k], RR_A0[k], RR_A1[k]});
            check($sformatf("fx_c%0d", k), {28'd0, fx_gnt0, fx_gnt1, fx_ack0, fx_ack1},
                  {28'd0, FX_G0[k], FX_G1[k], FX_A0[k], FX_A1[k]});
            if (k == 10) req0 = 0;
            if (k == 13) req1 = 0;
        end
        check("rr_rdata0", rr_rdata0, 32'hA5A50030);
        check("rr_rdata1", rr_rdata1, 32'h5A5A0031);
        check("fx_rdata0", fx_rdata0, 32'hA5A50030);
        check("fx_rdata1", fx_rdata1, 32'h5A5A0031);
        @(negedge clk);

        // Write on port 0 aborted by reset in the middle of ISSUE.
        req0 = 1; we0 = 1; addr0 = 8'h40; wdata0 = 32'hCAFEF00D;
        @(negedge clk);
        check("ab_we_high", {31'd0, rr_ram_we}, 32'd1);
        check("ab_ptr_pre", {31'd0, dut_rr.ptr}, 32'd1);
        req0 = 0;
        #2 rst_ = 1'b0;
        #1;
        check("ab_we_low", {31'd0, rr_ram_we}, 32'd0);
        check("ab_fx_we_low", {31'd0, fx_ram_we}, 32'd0);
        check("ab_gnt0", {31'd0, rr_gnt0}, 32'd0);
        check("ab_state", {30'd0, dut_rr.state}, {30'd0, IDLE});
        check("ab_ptr", {31'd0, dut_rr.ptr}, 32'd0);
        check("ab_wdata", rr_ram_wdata, 32'd0);
        check("ab_rdata1", rr_rdata1, 32'd0);
        @(negedge clk);
        rst_ = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("ab_noack%0d", k), {30'd0, rr_ack0, rr_ack1}, 32'd0);
        end

        // First sample after reset: tie goes to port 0 with the pointer reset.
        req0 = 1; we0 = 0; addr0 = 8'h10;
        req1 = 1; we1 = 0; addr1 = 8'h20;
        @(negedge clk);
        check("post_gnt", {30'd0, rr_gnt0, rr_gnt1}, 32'd2);
        req0 = 0; req1 = 0;
        @(negedge clk);
        @(negedge clk);
        check("post_ack", {30'd0, rr_ack0, rr_ack1}, 32'd2);
        check("post_rdata0", rr_rdata0, 32'hDEADBEEF);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning RAM byte-address width.
REQ-002 The block SHALL have parameter FIXED_PRIO, default 0, meaning 0 selects round-robin and 1 makes port 0 always win.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have the following ports, clock and reset first (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst_  in  1  async active-low reset.
- reqK  in  1  access request, K=0 (CPU data port), K=1 (debug/loader port).
- weK  in  1  1=write, 0=read.
- addrK  in  ADDR_W  byte address.
- sizeK  in  2  access size code, passed through.
- seK  in  1  sign-extend select, passed through.
- wdataK  in  32  write data.
- gntK  out  1  one-cycle grant pulse.
- ackK  out  1  one-cycle completion pulse.
- rdataK  out  32  read data, valid from ackK until the next read ack on port K.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write strobe.
- ram_size  out  2  RAM access size.
- ram_se  out  1  RAM sign-extend select.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, available one cycle after address is issued.

Function
REQ-005 The FSM SHALL have states IDLE, ISSUE and RESP; all transitions occur on the rising edge of clk.
REQ-006 In IDLE with no request, the FSM SHALL remain in IDLE.
REQ-007 In IDLE with any reqK=1, the FSM SHALL select a winner, latch that port's we/addr/size/se/wdata, and go to ISSUE.
REQ-008 ISSUE SHALL last exactly one cycle, during which gnt of the winner is 1 and ram_* is driven from the latched command.
REQ-009 ram_we SHALL be 1 only in ISSUE with a latched write; it SHALL be 0 in every other state.
REQ-010 The FSM SHALL go from ISSUE to RESP unconditionally.
REQ-011 In RESP, for a read, the block SHALL register ram_rdata into rdataK of the winner.
REQ-012 The FSM SHALL go from RESP to IDLE unconditionally.
REQ-013 ackK SHALL pulse in the cycle after RESP, for both reads and writes.
REQ-014 Latency SHALL be: req sampled at edge E, gnt in cycle E+1, ack in cycle E+3.
REQ-015 Peak throughput SHALL be one access per 3 cycles.
REQ-016 A requester SHALL hold reqK and its command stable until gntK is seen; the command is latched at grant, so changes after gnt are ignored.
REQ-017 A requester that keeps reqK=1 after gntK SHALL be treated as issuing a new request.
REQ-018 Round-robin (FIXED_PRIO=0): a 1-bit pointer names the preferred port; on simultaneous requests the preferred port wins; after granting port K the pointer becomes 1-K.
REQ-019 Round-robin: a single requester always wins regardless of the pointer.
REQ-020 With FIXED_PRIO=1, port 0 SHALL win every tie and the pointer SHALL be unused.
REQ-021 A request that drops before being sampled in IDLE SHALL be ignored; no gnt is issued.
REQ-022 ram_addr/size/se/wdata SHALL hold their latched values outside ISSUE.
REQ-023 rdataK SHALL be unchanged on writes and on the other port's accesses.
REQ-024 gnt0 and gnt1 SHALL never be 1 together, and ack0 and ack1 SHALL never be 1 together.

Reset
REQ-025 On rst_=0 the block SHALL immediately enter state IDLE, irrespective of clk.
REQ-026 On rst_=0 the block SHALL set gnt0, gnt1, ack0, ack1 and ram_we to 0.
REQ-027 On rst_=0 the block SHALL set ram_addr, ram_size, ram_se, ram_wdata, rdata0 and rdata1 to 0.
REQ-028 On rst_=0 the round-robin pointer SHALL be set to port 0.
REQ-029 Reset asserted during ISSUE SHALL drop ram_we in the same cycle and abort the access with no ack.
REQ-030 After rst_ deasserts, the first sampling edge SHALL follow the normal IDLE rules.

Structure
REQ-031 A shared package ram_arb_pkg SHALL hold the state encodings (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2), the port count (2) and the size-code constants.
REQ-032 One sub-module, rr_pick2, SHALL hold the combinational 2-way winner select (inputs req[1:0], ptr, fixed; output winner).

Verification
REQ-033 Read test: after reset, req0=1 read addr=8'h10, RAM holds 32'hDEADBEEF -> gnt0 at E+1, ram_we=0, ram_addr=8'h10, ack0 at E+3, rdata0=32'hDEADBEEF.
REQ-034 Write test: req1=1 write addr=8'h20, wdata=32'h12345678 -> ram_we=1 for exactly one cycle with ram_wdata=32'h12345678, ack1 at E+3, rdata1 unchanged.
REQ-035 Round-robin test: req0=req1=1 held for 4 accesses -> grant order 0,1,0,1, one gnt per 3 cycles, gnt never overlapping.
REQ-036 Fixed-priority test: FIXED_PRIO=1 with req0=req1=1 held for 3 accesses -> all grants to port 0; port 1 granted once req0 drops.
REQ-037 Reset-abort test: rst_=0 asserted mid-cycle during a write ISSUE -> ram_we falls without a clock edge, no ack, state IDLE, pointer=0.
